// File: rtl/elelock_ctrl.sv
// Electronic lock sequencer: turns one-hot keypad presses into code-entry sessions,
// drives the lock, and enforces a timed lockout after repeated wrong codes.
module elelock_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter logic [31:0] CODE     = 32'h0000_1234,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned LOCKOUT  = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       alarm,
  output logic       ok,
  output logic       err,
  output logic [2:0] digit_cnt
);

  localparam int unsigned TMAX = (TIMEOUT > LOCKOUT) ? TIMEOUT : LOCKOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {S_LOCKED, S_ENTRY, S_OPEN, S_LOCKOUT} state_e;

  state_e          state_q;
  logic [9:0]      prev_key_q;
  logic [TW-1:0]   timer_q;
  logic [FW-1:0]   fail_q;
  logic            mismatch_q;
  logic            lock_q, alarm_q, ok_q, err_q;
  logic [2:0]      digit_cnt_q;

  logic            key_valid, press, final_miss, last_digit;
  logic            timeout_hit, lockout_done, lockout_now;
  logic [3:0]      key_val, expect_digit;
  logic [31:0]     code_shift;
  logic [FW-1:0]   fail_inc;
  logic [TW-1:0]   timer_inc;

  assign key_valid = (tenkey != '0) && ((tenkey & (tenkey - 10'd1)) == '0);
  // A press needs a fully released keypad on the previous cycle.
  assign press     = key_valid && (prev_key_q == '0);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    key_val = '0;
    for (int i = 0; i < 10; i++) begin
      if (tenkey[i]) key_val = 4'(i);
    end
  end

  assign code_shift   = CODE >> (4 * (DIGITS - 1 - 32'(digit_cnt_q)));
  assign expect_digit = code_shift[3:0];
  assign final_miss   = ((state_q == S_ENTRY) && mismatch_q) || (key_val != expect_digit);
  assign last_digit   = (32'(digit_cnt_q) == DIGITS - 1);
  assign fail_inc     = fail_q + 1'b1;
  assign lockout_now  = (32'(fail_inc) == MAX_FAIL);
  assign timeout_hit  = (32'(timer_q) == TIMEOUT - 1);
  assign lockout_done = (32'(timer_q) == LOCKOUT - 1);
  assign timer_inc    = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOCKED;
      prev_key_q  <= '0;
      timer_q     <= '0;
      fail_q      <= '0;
      mismatch_q  <= 1'b0;
      lock_q      <= 1'b1;
      alarm_q     <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      digit_cnt_q <= '0;
    end else begin
      prev_key_q <= tenkey;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_LOCKED, S_ENTRY: begin
          if (press) begin
            timer_q <= '0;
            if (last_digit) begin
              digit_cnt_q <= '0;
              mismatch_q  <= 1'b0;
              if (!final_miss) begin
                state_q <= S_OPEN;
                lock_q  <= 1'b0;
                ok_q    <= 1'b1;
                fail_q  <= '0;
              end else begin
                err_q  <= 1'b1;
                fail_q <= fail_inc;
                if (lockout_now) begin
                  state_q <= S_LOCKOUT;
                  alarm_q <= 1'b1;
                end else begin
                  state_q <= S_LOCKED;
                end
              end
            end else begin
              state_q     <= S_ENTRY;
              digit_cnt_q <= digit_cnt_q + 3'd1;
              mismatch_q  <= final_miss;
            end
          end else if (state_q == S_ENTRY) begin
            if (timeout_hit) begin
              state_q     <= S_LOCKED;
              digit_cnt_q <= '0;
              mismatch_q  <= 1'b0;
              timer_q     <= '0;
            end else begin
              timer_q <= timer_inc;
            end
          end
        end
        S_OPEN: begin
          if (close) begin
            state_q <= S_LOCKED;
            lock_q  <= 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (lockout_done) begin
            state_q <= S_LOCKED;
            alarm_q <= 1'b0;
            fail_q  <= '0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: state_q <= S_LOCKED;
      endcase
    end
  end

  assign lock      = lock_q;
  assign alarm     = alarm_q;
  assign ok        = ok_q;
  assign err       = err_q;
  assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Self-checking bench for elelock_ctrl: vector table plus hand-written multi-cycle sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_elelock_ctrl;

  localparam int TIMEOUT  = 16;
  localparam int LOCKOUT  = 5000;
  localparam int MAX_FAIL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tenkey = '0;
  logic       close = 1'b0;
  logic       lock, alarm, ok, err;
  logic [2:0] digit_cnt;

  elelock_ctrl #(
    .DIGITS  (4),
    .CODE    (32'h0000_1234),
    .TIMEOUT (TIMEOUT),
    .MAX_FAIL(MAX_FAIL),
    .LOCKOUT (LOCKOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tenkey   (tenkey),
    .close    (close),
    .lock     (lock),
    .alarm    (alarm),
    .ok       (ok),
    .err      (err),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] tk;
    logic       cl;
    logic [6:0] exp;
  } vec_t;

  typedef enum {O_OK, O_ERR, O_LOCK, O_IGN} outcome_e;

  vec_t       vecs[$];
  logic [6:0] sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [6:0] dut_out;

  assign dut_out = {lock, alarm, ok, err, digit_cnt};

  function automatic logic [6:0] outv(input logic lk, input logic al, input logic okv,
                                      input logic erv, input logic [2:0] cnt);
    return {lk, al, okv, erv, cnt};
  endfunction

  function automatic logic [9:0] key(input int k);
    logic [9:0] one;
    one = 10'd1;
    return one << k;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: lock/alarm/ok/err/cnt got %b required %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] tk, input logic cl, input logic [6:0] exp);
    vec_t v;
    v.tk = tk; v.cl = cl; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic step(input string name, input logic [9:0] tk, input logic cl, input logic [6:0] exp);
    sb_q.push_back(exp);
    tenkey = tk;
    close  = cl;
    @(posedge clk);
    #1;
    check(name, dut_out, sb_q.pop_front());
  endtask

  task automatic press(input string name, input int k, input logic [6:0] ep, input logic [6:0] er);
    step(name, key(k), 1'b0, ep);
    step(name, '0, 1'b0, er);
  endtask

  task automatic enter4(input string name, input int a, input int b, input int c, input int d,
                        input outcome_e oc);
    int ks[4];
    logic [6:0] ep, er;
    ks[0] = a; ks[1] = b; ks[2] = c; ks[3] = d;
    for (int i = 0; i < 3; i++) begin
      ep = (oc == O_IGN) ? outv(1, 1, 0, 0, 0) : outv(1, 0, 0, 0, 3'(i + 1));
      press($sformatf("%s d%0d", name, i), ks[i], ep, ep);
    end
    case (oc)
      O_OK:    begin ep = outv(0, 0, 1, 0, 0); er = outv(0, 0, 0, 0, 0); end
      O_ERR:   begin ep = outv(1, 0, 0, 1, 0); er = outv(1, 0, 0, 0, 0); end
      O_LOCK:  begin ep = outv(1, 1, 0, 1, 0); er = outv(1, 1, 0, 0, 0); end
      default: begin ep = outv(1, 1, 0, 0, 0); er = outv(1, 1, 0, 0, 0); end
    endcase
    press($sformatf("%s d3", name), ks[3], ep, er);
  endtask

  // Reset is asserted away from the clock edge; outputs must change before any edge.
  task automatic async_reset(input string name);
    tenkey = '0;
    close  = 1'b0;
    reset  = 1'b1;
    #2;
    check(name, dut_out, outv(1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset values", dut_out, outv(1, 0, 0, 0, 0));
    reset = 1'b0;

    // Correct code with a release between presses, press ignored in OPEN, then close.
    add(key(1), 0, outv(1, 0, 0, 0, 1));
    add('0,     0, outv(1, 0, 0, 0, 1));
    add(key(2), 0, outv(1, 0, 0, 0, 2));
    add('0,     0, outv(1, 0, 0, 0, 2));
    add(key(3), 0, outv(1, 0, 0, 0, 3));
    add('0,     0, outv(1, 0, 0, 0, 3));
    add(key(4), 0, outv(0, 0, 1, 0, 0));
    add('0,     0, outv(0, 0, 0, 0, 0));
    add(key(1), 0, outv(0, 0, 0, 0, 0));
    add('0,     0, outv(0, 0, 0, 0, 0));
    add('0,     1, outv(1, 0, 0, 0, 0));
    add('0,     0, outv(1, 0, 0, 0, 0));
    // Input hygiene: held key counts once, multi-bit is no key, no press without release.
    for (int i = 0; i < 10; i++) add(key(1), 0, outv(1, 0, 0, 0, 1));
    add('0,     0, outv(1, 0, 0, 0, 1));
    add(10'h006, 0, outv(1, 0, 0, 0, 1));
    add(10'h002, 0, outv(1, 0, 0, 0, 1));
    add('0,     0, outv(1, 0, 0, 0, 1));
    add(key(2), 0, outv(1, 0, 0, 0, 2));
    add(key(3), 0, outv(1, 0, 0, 0, 2));
    add('0,     0, outv(1, 0, 0, 0, 2));

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].tk, vecs[i].cl, vecs[i].exp);

    // Two idle cycles already elapsed since the press of 2; abort on the 16th.
    for (int i = 3; i <= TIMEOUT; i++)
      step($sformatf("timeout idle%0d", i), '0, 0,
           (i < TIMEOUT) ? outv(1, 0, 0, 0, 2) : outv(1, 0, 0, 0, 0));
    enter4("after timeout", 1, 2, 3, 4, O_OK);
    step("close", '0, 1, outv(1, 0, 0, 0, 0));

    // Press landing exactly on the idle cycle that would time out.
    step("tcyc d0", key(1), 0, outv(1, 0, 0, 0, 1));
    for (int i = 1; i < TIMEOUT; i++)
      step($sformatf("tcyc idle%0d", i), '0, 0, outv(1, 0, 0, 0, 1));
    step("tcyc d1 on timeout", key(2), 0, outv(1, 0, 0, 0, 2));
    step("tcyc rel", '0, 0, outv(1, 0, 0, 0, 2));
    press("tcyc d2", 3, outv(1, 0, 0, 0, 3), outv(1, 0, 0, 0, 3));
    press("tcyc d3", 4, outv(0, 0, 1, 0, 0), outv(0, 0, 0, 0, 0));
    step("tcyc close", '0, 1, outv(1, 0, 0, 0, 0));

    // Three wrong codes, lockout of exactly LOCKOUT cycles, correct code ignored meanwhile.
    enter4("wrong1", 1, 2, 3, 5, O_ERR);
    enter4("wrong2", 1, 2, 3, 5, O_ERR);
    enter4("wrong3", 1, 2, 3, 5, O_LOCK);
    enter4("during lockout", 1, 2, 3, 4, O_IGN);
    for (int n = 11; n <= LOCKOUT; n++)
      step($sformatf("alarm cyc%0d", n), '0, 0, outv(1, 1, 0, 0, 0));
    step("lockout end", '0, 0, outv(1, 0, 0, 0, 0));
    enter4("after lockout", 1, 2, 3, 4, O_OK);
    step("close2", '0, 1, outv(1, 0, 0, 0, 0));

    // Reset mid-entry clears the fail count accumulated before it.
    enter4("pre1", 1, 2, 3, 5, O_ERR);
    enter4("pre2", 1, 2, 3, 5, O_ERR);
    press("mid d0", 1, outv(1, 0, 0, 0, 1), outv(1, 0, 0, 0, 1));
    press("mid d1", 2, outv(1, 0, 0, 0, 2), outv(1, 0, 0, 0, 2));
    press("mid d2", 3, outv(1, 0, 0, 0, 3), outv(1, 0, 0, 0, 3));
    async_reset("reset mid-entry");
    step("post reset idle", '0, 0, outv(1, 0, 0, 0, 0));
    enter4("post1", 1, 2, 3, 5, O_ERR);
    enter4("post2", 1, 2, 3, 5, O_ERR);
    enter4("post3", 1, 2, 3, 5, O_LOCK);
    for (int i = 0; i < 20; i++)
      step("lockout before reset", '0, 0, outv(1, 1, 0, 0, 0));
    async_reset("reset in lockout");
    step("post lockout reset idle", '0, 0, outv(1, 0, 0, 0, 0));
    enter4("fresh wrong", 1, 2, 3, 5, O_ERR);
    enter4("fresh good", 1, 2, 3, 4, O_OK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
